// File: rtl/note_player.sv
// note_player
//    Follows the beat index from player_control. On every ibeat change it
//    latches that beat's note divider and restarts a square-wave tone, with a
//    short rest between repeated identical notes. Produces signed 16-bit
//    samples for the speaker serializer.
// Ports
//    clk           : system clock, rising edge
//    reset         : synchronous, active-high
//    ibeat         : beat index (12 bits)
//    beat_note_div : divider for the current ibeat, valid with ibeat
//    volume        : amplitude step, 0 = silent, 7 = max
//    mute          : forces zero output; tone phase keeps running
//    note_start    : one-cycle pulse when a new note is loaded
//    audio_left    : signed two's-complement sample
//    audio_right   : copy of audio_left
module note_player #(
   parameter int DIV_W      = 22,
   parameter int GAP_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [11:0]      ibeat,
   input  logic [DIV_W-1:0] beat_note_div,
   input  logic [2:0]       volume,
   input  logic             mute,
   output logic             note_start,
   output logic [15:0]      audio_left,
   output logic [15:0]      audio_right
);

   localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

   logic [11:0]      ibeat_q,      ibeat_d;
   logic [DIV_W-1:0] div_q,        div_d;
   logic [DIV_W-1:0] cnt_q,        cnt_d;
   logic             phase_q,      phase_d;
   logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
   logic             note_start_q, note_start_d;
   logic [15:0]      audio_q,      audio_d;

   logic [DIV_W-1:0] half;
   logic             silent;
   logic             in_gap;
   logic [15:0]      amp;

   always_comb begin
      ibeat_d      = ibeat_q;
      div_d        = div_q;
      cnt_d        = cnt_q;
      phase_d      = phase_q;
      gap_cnt_d    = gap_cnt_q;
      note_start_d = 1'b0;

      half   = div_q >> 1;
      silent = (div_q < DIV_W'(2));
      in_gap = (gap_cnt_q != '0);
      amp    = {1'b0, volume, 12'b0};

      // Sample reflects the state before this edge, so audio lags state by one cycle.
      if (mute || silent || in_gap || (volume == 3'd0))
         audio_d = '0;
      else
         audio_d = phase_q ? amp : (16'h0000 - amp);

      if (ibeat != ibeat_q) begin
         ibeat_d      = ibeat;
         div_d        = beat_note_div;
         cnt_d        = '0;
         phase_d      = 1'b1;
         note_start_d = 1'b1;
         // Rest only when the new note repeats an audible previous divider.
         if ((beat_note_div == div_q) && (beat_note_div >= DIV_W'(2)))
            gap_cnt_d = GAP_LOAD;
         else
            gap_cnt_d = '0;
      end else if (in_gap) begin
         gap_cnt_d = gap_cnt_q - GAP_W'(1);
         cnt_d     = '0;
         phase_d   = 1'b1;
      end else if (!silent) begin
         if (cnt_q == half - DIV_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ibeat_q      <= 12'hFFF;
         div_q        <= '0;
         cnt_q        <= '0;
         phase_q      <= 1'b1;
         gap_cnt_q    <= '0;
         note_start_q <= 1'b0;
         audio_q      <= '0;
      end else begin
         ibeat_q      <= ibeat_d;
         div_q        <= div_d;
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
         gap_cnt_q    <= gap_cnt_d;
         note_start_q <= note_start_d;
         audio_q      <= audio_d;
      end
   end

   assign note_start  = note_start_q;
   assign audio_left  = audio_q;
   assign audio_right = audio_q;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player
//    Directed scenarios followed by randomized beats, volume, mute and reset,
//    compared every cycle against a reference model that derives the expected
//    sample from the time elapsed since the current note was loaded.
module tb_note_player;

   localparam int DIV_W = 22;
   localparam int G     = 16;

   logic             clk;
   logic             reset;
   logic [11:0]      ibeat;
   logic [DIV_W-1:0] beat_note_div;
   logic [2:0]       volume;
   logic             mute;
   logic             note_start;
   logic [15:0]      audio_left;
   logic [15:0]      audio_right;

   int checks = 0;
   int errors = 0;

   // Reference model: current note divider, rest length for that note,
   // edges elapsed since it was loaded, and the last beat seen.
   int          m_div;
   int          m_gap;
   int          m_elapsed;
   logic [11:0] m_beat;

   note_player #(.DIV_W(DIV_W), .GAP_CYCLES(G)) dut (
      .clk          (clk),
      .reset        (reset),
      .ibeat        (ibeat),
      .beat_note_div(beat_note_div),
      .volume       (volume),
      .mute         (mute),
      .note_start   (note_start),
      .audio_left   (audio_left),
      .audio_right  (audio_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Square wave: high for the first half-period after the rest, then
   // alternating every half = div/2 cycles.
   function automatic logic [15:0] model_sample();
      int half;
      int k;
      logic [15:0] amp;
      amp = 16'(int'(volume) * 4096);
      if (m_div < 2 || m_elapsed < m_gap || mute || volume == 3'd0)
         return 16'h0000;
      half = m_div / 2;
      k    = m_elapsed - m_gap;
      if (((k / half) % 2) == 0)
         return amp;
      return 16'h0000 - amp;
   endfunction

   // Advance one clock edge with the inputs currently driven and compare.
   task automatic step();
      logic [15:0] e_audio;
      logic        e_ns;
      if (reset) begin
         e_audio   = 16'h0000;
         e_ns      = 1'b0;
         m_beat    = 12'hFFF;
         m_div     = 0;
         m_gap     = 0;
         m_elapsed = 0;
      end else begin
         e_audio = model_sample();
         if (ibeat != m_beat) begin
            m_gap     = (int'(beat_note_div) == m_div && m_div >= 2) ? G : 0;
            m_div     = int'(beat_note_div);
            m_beat    = ibeat;
            m_elapsed = 0;
            e_ns      = 1'b1;
         end else begin
            m_elapsed++;
            e_ns = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("audio_left",  {16'h0, audio_left},  {16'h0, e_audio});
      check("audio_right", {16'h0, audio_right}, {16'h0, e_audio});
      check("note_start",  {31'h0, note_start},  {31'h0, e_ns});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset         = 1'b1;
      ibeat         = 12'd0;
      beat_note_div = DIV_W'(8);
      volume        = 3'd7;
      mute          = 1'b0;
      m_beat        = 12'hFFF;
      m_div         = 0;
      m_gap         = 0;
      m_elapsed     = 0;

      // 1: reset, then beat 0 with divider 8 at full volume
      run(3);
      reset = 1'b0;
      run(20);

      // 2: new beat, different divider, no rest
      ibeat = 12'd1; beat_note_div = DIV_W'(6);
      run(15);

      // 3: repeated divider inserts the rest
      ibeat = 12'd2;
      run(30);

      // divider changes without a beat change are ignored
      beat_note_div = DIV_W'(20);
      run(10);

      // 4: silent dividers still pulse note_start
      ibeat = 12'd3; beat_note_div = DIV_W'(0);
      run(6);
      ibeat = 12'd4; beat_note_div = DIV_W'(1);
      run(6);
      ibeat = 12'd5; beat_note_div = DIV_W'(1);
      run(6);

      // 5: volume and mute mid-note
      ibeat = 12'd6; beat_note_div = DIV_W'(10);
      run(2);
      volume = 3'd2;
      run(12);
      mute = 1'b1;
      run(7);
      mute = 1'b0;
      run(10);
      volume = 3'd0;
      run(4);
      volume = 3'd7;

      // beat change during a rest restarts it with the repeated divider
      ibeat = 12'd7;
      run(5);
      ibeat = 12'd8;
      run(25);

      // 6: reset mid-gap, then restart as in scenario 1
      ibeat = 12'd9;
      run(4);
      reset = 1'b1; ibeat = 12'd0; beat_note_div = DIV_W'(8);
      run(2);
      reset = 1'b0;
      run(12);

      // FFF straight after reset is not a change
      reset = 1'b1; ibeat = 12'hFFF;
      run(2);
      reset = 1'b0;
      run(5);

      // randomized section
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            ibeat = ($urandom_range(0, 3) == 0) ? 12'($urandom) : ibeat + 12'd1;
            case ($urandom_range(0, 3))
               0:       beat_note_div = DIV_W'(m_div);
               1:       beat_note_div = DIV_W'($urandom_range(0, 3));
               default: beat_note_div = DIV_W'($urandom_range(2, 40));
            endcase
         end else if ($urandom_range(0, 7) == 0) begin
            beat_note_div = DIV_W'($urandom_range(0, 40));
         end
         if ($urandom_range(0, 31) == 0) volume = 3'($urandom);
         if ($urandom_range(0, 15) == 0) mute = ~mute;
         reset = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
